// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_DRAIN,
    F_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, ir} entries; flush beats push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  fetch_entry_t               i_data,
  input  logic                       i_pop,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output fetch_entry_t               o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; needs no reset since empty entries are never presented.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch unit: Wishbone classic read master feeding a prefetch
// buffer, with jump redirect, abandoned-read draining and sticky bus fault.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter logic [31:0] PC_RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN        = fetch_pkg::NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [31:0] PC_O,
  output logic [31:0] IR_O,
  output logic        execute,
  input  logic        ins_busy,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        fault
);

  localparam int unsigned   CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_drain_adr;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_cnt_pop;
  logic          w_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic          w_push;
  logic          w_pop;
  logic          w_resp;
  logic [31:0]   w_target;

  assign w_resp       = wb_ack_i | wb_err_i;
  assign w_target     = jump_target & ~32'd3;
  assign w_pop        = !w_empty && !ins_busy && !jump;
  assign w_push       = (r_state == F_REQ) && wb_ack_i && !wb_err_i && !jump;
  assign w_cnt_pop    = w_count - CW'(w_pop);
  assign w_push_entry = {r_fetch_pc, wb_dat_i};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_flush (jump),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Fetch state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= F_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state decision; jump dominates every other condition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      F_IDLE: begin
        if (!jump && (w_cnt_pop < LP_DEPTH)) w_state_nxt = F_REQ;
      end
      F_REQ: begin
        if (jump)          w_state_nxt = w_resp ? F_REQ : F_DRAIN;
        else if (wb_err_i) w_state_nxt = F_FAULT;
        else if (wb_ack_i) w_state_nxt = ((w_cnt_pop + 1'b1) < LP_DEPTH) ? F_REQ : F_IDLE;
      end
      F_DRAIN: begin
        if (w_resp) w_state_nxt = F_REQ;
      end
      F_FAULT: begin
        if (jump) w_state_nxt = F_IDLE;
      end
      default: w_state_nxt = F_IDLE;
    endcase
  end

  // Fetch address tracking; the abandoned address is latched so the bus
  // stays stable while draining even though fetch_pc already moved on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc  <= PC_RESET_VECTOR;
      r_drain_adr <= PC_RESET_VECTOR;
    end else begin
      if (jump)        r_fetch_pc <= w_target;
      else if (w_push) r_fetch_pc <= r_fetch_pc + 32'd4;
      if ((r_state == F_REQ) && jump && !w_resp) r_drain_adr <= r_fetch_pc;
    end
  end

  // Bus and execute-side outputs, all sourced from registers.
  always_comb begin
    wb_cyc_o = (r_state == F_REQ) || (r_state == F_DRAIN);
    wb_stb_o = wb_cyc_o;
    wb_we_o  = 1'b0;
    wb_dat_o = '0;
    wb_adr_o = (r_state == F_DRAIN) ? r_drain_adr : r_fetch_pc;
    fault    = (r_state == F_FAULT);
    execute  = !w_empty;
    PC_O     = w_empty ? r_fetch_pc : w_head.pc;
    IR_O     = w_empty ? NOP_INSN   : w_head.ir;
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: fixed vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_fetch_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RSTV  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic [31:0] PC_O, IR_O;
  logic        execute;
  logic        ins_busy = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        fault;

  always #5 clk = ~clk;

  fetch_prefetch #(
    .DEPTH           (DEPTH),
    .PC_RESET_VECTOR (RSTV),
    .NOP_INSN        (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i),
    .PC_O        (PC_O),
    .IR_O        (IR_O),
    .execute     (execute),
    .ins_busy    (ins_busy),
    .jump        (jump),
    .jump_target (jump_target),
    .fault       (fault)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // ---------------- slave configuration ----------------
  int unsigned s_waits = 0;
  int unsigned s_wcnt  = 0;
  bit          s_rand  = 1'b0;
  bit          s_err_en = 1'b0;
  logic [31:0] s_err_adr = '0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  ent_t        q[$];
  bit          m_req, m_drain, m_fault;
  logic [31:0] m_fpc, m_dadr;

  function automatic void m_reset();
    q.delete();
    m_req   = 1'b0;
    m_drain = 1'b0;
    m_fault = 1'b0;
    m_fpc   = RSTV;
    m_dadr  = RSTV;
  endfunction

  function automatic void m_update(input bit busy, input bit jmp, input logic [31:0] tgt,
                                   input bit ack, input bit err, input logic [31:0] dat);
    bit pop;
    pop = (q.size() != 0) && !busy;
    if (jmp) begin
      q.delete();
      if (m_fault) m_fault = 1'b0;
      else if (m_req) begin
        if (!(ack || err)) begin
          m_req   = 1'b0;
          m_drain = 1'b1;
          m_dadr  = m_fpc;
        end
      end else if (m_drain) begin
        if (ack || err) begin
          m_drain = 1'b0;
          m_req   = 1'b1;
        end
      end
      m_fpc = tgt & ~32'd3;
    end else begin
      if (pop) void'(q.pop_front());
      if (m_fault) begin
      end else if (m_drain) begin
        if (ack || err) begin
          m_drain = 1'b0;
          m_req   = 1'b1;
        end
      end else if (m_req) begin
        if (err) begin
          m_fault = 1'b1;
          m_req   = 1'b0;
        end else if (ack) begin
          q.push_back({m_fpc, dat});
          m_fpc = m_fpc + 32'd4;
          if (q.size() >= DEPTH) m_req = 1'b0;
        end
      end else begin
        if (q.size() < DEPTH) m_req = 1'b1;
      end
    end
  endfunction

  task automatic cmp_model();
    bit exe;
    exe = (q.size() != 0);
    chk("cyc", wb_cyc_o, m_req || m_drain);
    chk("stb", wb_stb_o, m_req || m_drain);
    chk("we", wb_we_o, 1'b0);
    chk("dat_o", wb_dat_o, 32'h0);
    if (m_req || m_drain) chk("adr", wb_adr_o, m_drain ? m_dadr : m_fpc);
    chk("execute", execute, exe);
    chk("pc", PC_O, exe ? q[0].pc : m_fpc);
    chk("ir", IR_O, exe ? q[0].ir : NOP);
    chk("fault", fault, m_fault);
  endtask

  // Drive inputs for the coming edge, answer the bus, advance the model.
  task automatic drive(input bit busy, input bit jmp, input logic [31:0] tgt);
    bit go;
    ins_busy    = busy;
    jump        = jmp;
    jump_target = tgt;
    wb_ack_i    = 1'b0;
    wb_err_i    = 1'b0;
    wb_dat_i    = $urandom();
    if (wb_cyc_o && wb_stb_o) begin
      if (s_rand) go = ($urandom_range(0, 2) != 0);
      else        go = (s_wcnt >= s_waits);
      if (go) begin
        s_wcnt = 0;
        if (s_err_en && (wb_adr_o == s_err_adr)) wb_err_i = 1'b1;
        else begin
          wb_ack_i = 1'b1;
          wb_dat_i = memval(wb_adr_o);
        end
      end else begin
        s_wcnt++;
      end
    end else begin
      s_wcnt = 0;
    end
    m_update(busy, jmp, tgt, wb_ack_i, wb_err_i, wb_dat_i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ins_busy = 1'b0; jump = 1'b0; jump_target = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    s_wcnt = 0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_adr", wb_adr_o, RSTV);
    chk("rst_execute", execute, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_pc", PC_O, RSTV);
    chk("rst_ir", IR_O, NOP);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          busy;
    bit          jmp;
    logic [31:0] tgt;
    bit          e_exec;
    logic [31:0] e_pc;
    bit          e_cyc;
    logic [31:0] e_adr;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h000};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b1, 32'h004};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b1, 32'h008};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h00C};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h010};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h014};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b0, 32'h000};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b0, 32'h000};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b0, 32'h000};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h018};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h01C};
    tbl[11] = '{1'b0, 1'b1, 32'h103, 1'b1, 32'h014, 1'b1, 32'h020};
    tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h100, 1'b1, 32'h100};
    tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h104};
    tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h108};

    // Zero-wait streaming, buffer fill under stall, jump with ack and consume.
    s_waits = 0; s_rand = 1'b0; s_err_en = 1'b0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      cmp_model();
      chk("tbl_exec", execute, tbl[i].e_exec);
      chk("tbl_pc", PC_O, tbl[i].e_pc);
      chk("tbl_ir", IR_O, tbl[i].e_exec ? memval(tbl[i].e_pc) : NOP);
      chk("tbl_cyc", wb_cyc_o, tbl[i].e_cyc);
      if (tbl[i].e_cyc) chk("tbl_adr", wb_adr_o, tbl[i].e_adr);
      drive(tbl[i].busy, tbl[i].jmp, tbl[i].tgt);
    end

    // Jump during a 3-wait-state read: the read is drained and discarded.
    s_waits = 3;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      cmp_model();
      case (k)
        3: begin
          chk("drain_cyc", wb_cyc_o, 1'b1);
          chk("drain_adr", wb_adr_o, 32'h0);
          chk("drain_exec", execute, 1'b0);
        end
        4: begin
          chk("redir_adr", wb_adr_o, 32'h100);
          chk("redir_exec", execute, 1'b0);
        end
        7: chk("redir_wait_exec", execute, 1'b0);
        8: begin
          chk("redir_first_exec", execute, 1'b1);
          chk("redir_first_pc", PC_O, 32'h100);
        end
        default: ;
      endcase
      drive(1'b0, k == 2, 32'h0000_0103);
    end

    // Bus error at 0x10: sticky fault, buffered entries still delivered.
    s_waits = 0; s_err_en = 1'b1; s_err_adr = 32'h10;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      cmp_model();
      case (k)
        4: chk("flt_pc0", PC_O, 32'h0);
        5: chk("flt_pc4", PC_O, 32'h4);
        6: begin
          chk("flt_pc8", PC_O, 32'h8);
          chk("flt_fault", fault, 1'b1);
          chk("flt_cyc", wb_cyc_o, 1'b0);
        end
        7: chk("flt_pcC", PC_O, 32'hC);
        8: begin
          chk("flt_empty", execute, 1'b0);
          chk("flt_sticky", fault, 1'b1);
        end
        10: chk("flt_clear", fault, 1'b0);
        11: begin
          chk("flt_resume_cyc", wb_cyc_o, 1'b1);
          chk("flt_resume_adr", wb_adr_o, 32'h40);
        end
        12: chk("flt_resume_pc", PC_O, 32'h40);
        default: ;
      endcase
      drive(k < 4, k == 9, 32'h40);
    end
    s_err_en = 1'b0;

    // Asynchronous reset in the middle of a pending read.
    s_waits = 5;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cmp_model();
      drive(1'b0, 1'b0, 32'h0);
    end
    @(negedge clk);
    chk("arst_pre_cyc", wb_cyc_o, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_cyc", wb_cyc_o, 1'b0);
    chk("arst_stb", wb_stb_o, 1'b0);
    chk("arst_adr", wb_adr_o, RSTV);
    ins_busy = 1'b0; jump = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    s_wcnt = 0;
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    s_waits = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cmp_model();
      if (k == 0) chk("arst_restart_adr", wb_adr_o, RSTV);
      drive(1'b0, 1'b0, 32'h0);
    end

    // Randomized traffic: random slave latency, stalls, jumps and errors.
    s_rand = 1'b1; s_err_en = 1'b1; s_err_adr = 32'h28;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      cmp_model();
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 255));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
